// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: transfer-mode/address codes, status codes and
// the byte-lane strobe decode used by the slave interface.
package nubus_pkg;

  // {tm1, tm0, ad1, ad0} in asserted sense at start
  localparam logic [3:0] TMAD_RD_BYTE_0 = 4'b0000;
  localparam logic [3:0] TMAD_RD_BYTE_1 = 4'b0001;
  localparam logic [3:0] TMAD_RD_BYTE_2 = 4'b0010;
  localparam logic [3:0] TMAD_RD_BYTE_3 = 4'b0011;
  localparam logic [3:0] TMAD_RD_WORD   = 4'b0100;
  localparam logic [3:0] TMAD_RD_BLOCK  = 4'b0101;
  localparam logic [3:0] TMAD_RD_HALF_0 = 4'b0110;
  localparam logic [3:0] TMAD_RD_HALF_1 = 4'b0111;
  localparam logic [3:0] TMAD_WR_BYTE_0 = 4'b1000;
  localparam logic [3:0] TMAD_WR_BYTE_1 = 4'b1001;
  localparam logic [3:0] TMAD_WR_BYTE_2 = 4'b1010;
  localparam logic [3:0] TMAD_WR_BYTE_3 = 4'b1011;
  localparam logic [3:0] TMAD_WR_WORD   = 4'b1100;
  localparam logic [3:0] TMAD_WR_BLOCK  = 4'b1101;
  localparam logic [3:0] TMAD_WR_HALF_0 = 4'b1110;
  localparam logic [3:0] TMAD_WR_HALF_1 = 4'b1111;

  // acknowledge status on {tm1, tm0}, asserted sense
  localparam logic [1:0] TM_NOP      = 2'b00;
  localparam logic [1:0] TM_ERROR    = 2'b01;
  localparam logic [1:0] TM_TIMEOUT  = 2'b10;
  localparam logic [1:0] TM_TRYAGAIN = 2'b11;

  // Block transfers are serviced as a single word.
  function automatic logic [3:0] tmad_strobe(input logic [3:0] tmad);
    logic [3:0] strb;
    strb = 4'b0000;
    if (!tmad[2]) begin
      strb = 4'b0001 << tmad[1:0];
    end else begin
      case (tmad[1:0])
        2'b10:   strb = 4'b0011;
        2'b11:   strb = 4'b1100;
        default: strb = 4'b1111;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/nubus_slave.sv
// NuBus single-beat slave: samples the bus on the falling clock edge, drives it
// on the rising edge, and forwards accepted cycles to a valid/ready memory port.
module nubus_slave
  import nubus_pkg::*;
(
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic [3:0]  nub_idn,
  inout  wire  [31:0] nub_adn,
  inout  wire         nub_tm0n,
  inout  wire         nub_tm1n,
  input  logic        nub_startn,
  inout  wire         nub_ackn,
  inout  wire         nub_rqstn,
  inout  wire  [3:0]  nub_arbn,
  inout  wire         nub_nmrqn,
  inout  wire         nub_pfwn,
  inout  wire         nub_spn,
  inout  wire         nub_spvn,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_myslot,
  output logic        mem_myexp
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [31:0] ad_in;
  logic [3:0]  card_id;
  assign ad_in   = ~nub_adn;
  assign card_id = ~nub_idn;

  logic        start_reg;
  logic [1:0]  tm_reg;
  logic [31:0] addr_reg;
  logic        ready_reg;
  logic [31:0] rdata_s_reg;

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      start_reg   <= 1'b0;
      tm_reg      <= 2'b00;
      addr_reg    <= '0;
      ready_reg   <= 1'b0;
      rdata_s_reg <= '0;
    end else begin
      start_reg   <= ~nub_startn;
      tm_reg      <= {~nub_tm1n, ~nub_tm0n};
      addr_reg    <= ad_in;
      ready_reg   <= mem_ready;
      rdata_s_reg <= mem_rdata;
    end
  end

  logic slot_hit;
  logic exp_hit;
  logic accept;
  assign slot_hit = (addr_reg[31:24] == {4'hF, card_id});
  assign exp_hit  = (addr_reg[31:28] == card_id) && (card_id != 4'h0) && (card_id != 4'hF);
  assign accept   = start_reg && (slot_hit || exp_hit);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic        write_reg;
  logic [31:0] rdata_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_MEM;
      ST_MEM:  if (ready_reg) state_next = ST_ACK;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_reg  <= ST_IDLE;
      mem_valid  <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_addr   <= '0;
      mem_myslot <= 1'b0;
      mem_myexp  <= 1'b0;
      write_reg  <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mem_valid  <= 1'b1;
            mem_addr   <= {addr_reg[31:2], 2'b00};
            mem_wstrb  <= tm_reg[1] ? tmad_strobe({tm_reg, addr_reg[1:0]}) : 4'b0000;
            mem_myslot <= slot_hit;
            mem_myexp  <= exp_hit;
            write_reg  <= tm_reg[1];
          end
        end
        ST_MEM: begin
          if (ready_reg) begin
            mem_valid  <= 1'b0;
            mem_wstrb  <= 4'b0000;
            mem_myslot <= 1'b0;
            mem_myexp  <= 1'b0;
            rdata_reg  <= rdata_s_reg;
          end
        end
        default: begin
          write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wdata = (mem_valid && write_reg) ? ad_in : '0;

  // Open-collector drive: a line is pulled low only where the asserted value is 1.
  logic ack_drive;
  logic data_drive;
  assign ack_drive  = (state_reg == ST_ACK);
  assign data_drive = ack_drive && !write_reg;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_ad
      assign nub_adn[gi] = (data_drive && rdata_reg[gi]) ? 1'b0 : 1'bz;
    end
  endgenerate

  assign nub_ackn = ack_drive ? 1'b0 : 1'bz;
  assign nub_tm1n = (ack_drive && TM_NOP[1]) ? 1'b0 : 1'bz;
  assign nub_tm0n = (ack_drive && TM_NOP[0]) ? 1'b0 : 1'bz;

  assign nub_rqstn = 1'bz;
  assign nub_arbn  = 4'bzzzz;
  assign nub_nmrqn = 1'bz;
  assign nub_pfwn  = 1'bz;
  assign nub_spn   = 1'bz;
  assign nub_spvn  = 1'bz;

endmodule

// File: tb/tb_nubus_slave.sv
// Directed bench for nubus_slave: bus master, pulled-up open-collector lines
// and a falling-edge local memory with a fixed ready delay.
module tb_nubus_slave;
  import nubus_pkg::*;

  logic        nub_clkn;
  logic        nub_resetn;
  logic [3:0]  nub_idn;
  logic        nub_startn;
  wire  [31:0] nub_adn;
  wire         nub_tm0n, nub_tm1n, nub_ackn;
  wire         nub_rqstn, nub_nmrqn, nub_pfwn, nub_spn, nub_spvn;
  wire  [3:0]  nub_arbn;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_myslot;
  logic        mem_myexp;

  // master drive, asserted sense
  logic        drv_ad_en;
  logic [31:0] drv_ad;
  logic        drv_tm_en;
  logic [1:0]  drv_tm;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_ad
      pullup (nub_adn[gi]);
      assign nub_adn[gi] = (drv_ad_en && drv_ad[gi]) ? 1'b0 : 1'bz;
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_arb
      pullup (nub_arbn[gi]);
    end
  endgenerate
  pullup (nub_tm0n);
  pullup (nub_tm1n);
  pullup (nub_ackn);
  pullup (nub_rqstn);
  pullup (nub_nmrqn);
  pullup (nub_pfwn);
  pullup (nub_spn);
  pullup (nub_spvn);
  assign nub_tm1n = (drv_tm_en && drv_tm[1]) ? 1'b0 : 1'bz;
  assign nub_tm0n = (drv_tm_en && drv_tm[0]) ? 1'b0 : 1'bz;

  nubus_slave dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .nub_idn    (nub_idn),
    .nub_adn    (nub_adn),
    .nub_tm0n   (nub_tm0n),
    .nub_tm1n   (nub_tm1n),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .nub_rqstn  (nub_rqstn),
    .nub_arbn   (nub_arbn),
    .nub_nmrqn  (nub_nmrqn),
    .nub_pfwn   (nub_pfwn),
    .nub_spn    (nub_spn),
    .nub_spvn   (nub_spvn),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_myslot (mem_myslot),
    .mem_myexp  (mem_myexp)
  );

  initial nub_clkn = 1'b0;
  always #5 nub_clkn = ~nub_clkn;

  // local memory: ready goes high on the 5th falling edge of a request
  logic [31:0] mem [0:63];
  int          dly_cnt;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
  end

  always @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      dly_cnt   <= 0;
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
      dly_cnt   <= 0;
    end else if (mem_valid) begin
      if (dly_cnt == 4) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else begin
      dly_cnt <= 0;
    end
  end

  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  tmad;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic        exp_slot;
    logic        exp_exp;
    logic [31:0] exp_rdata;
  } txn_t;

  function automatic txn_t mk(input logic [3:0] id, input logic [3:0] tmad,
                              input logic [31:0] addr, input logic [31:0] ea,
                              input logic [3:0] ews, input logic es, input logic ee,
                              input logic [31:0] erd);
    txn_t t;
    t.id = id; t.tmad = tmad; t.addr = addr; t.wdata = 32'h8765_4321;
    t.exp_addr = ea; t.exp_wstrb = ews; t.exp_slot = es; t.exp_exp = ee;
    t.exp_rdata = erd;
    return t;
  endfunction

  task automatic start_cycle(input logic [3:0] id, input logic [3:0] tmad, input logic [31:0] addr);
    @(posedge nub_clkn); #1;
    nub_idn    = ~id;
    nub_startn = 1'b0;
    drv_ad_en  = 1'b1;
    drv_ad     = addr;
    drv_tm_en  = 1'b1;
    drv_tm     = tmad[3:2];
  endtask

  task automatic do_txn(input int idx, input txn_t t);
    int  cyc;
    bit  got_ack;
    bit  is_wr;
    is_wr = t.tmad[3];
    start_cycle(t.id, t.tmad, t.addr);
    @(posedge nub_clkn); #1;
    nub_startn = 1'b1;
    drv_tm_en  = 1'b0;
    if (is_wr) drv_ad = t.wdata;
    else       drv_ad_en = 1'b0;
    #1;
    check($sformatf("t%0d mem_valid", idx), {31'd0, mem_valid}, 32'd1);
    check($sformatf("t%0d mem_addr", idx), mem_addr, t.exp_addr);
    check($sformatf("t%0d mem_wstrb", idx), {28'd0, mem_wstrb}, {28'd0, t.exp_wstrb});
    check($sformatf("t%0d myslot/myexp", idx), {30'd0, mem_myslot, mem_myexp},
          {30'd0, t.exp_slot, t.exp_exp});
    cyc = 1;
    got_ack = 1'b0;
    while (!got_ack && cyc < 30) begin
      @(posedge nub_clkn); #2;
      cyc++;
      if (nub_ackn === 1'b0) got_ack = 1'b1;
    end
    check($sformatf("t%0d ack seen", idx), {31'd0, got_ack}, 32'd1);
    check($sformatf("t%0d ack clock", idx), cyc, 32'd7);
    drv_ad_en = 1'b0;
    #1;
    check($sformatf("t%0d valid at ack", idx), {31'd0, mem_valid}, 32'd0);
    check($sformatf("t%0d status", idx), {30'd0, ~nub_tm1n, ~nub_tm0n}, {30'd0, TM_NOP});
    if (is_wr) check($sformatf("t%0d ad idle on write ack", idx), nub_adn, 32'hFFFF_FFFF);
    else       check($sformatf("t%0d read data", idx), ~nub_adn, t.exp_rdata);
    @(posedge nub_clkn); #2;
    check($sformatf("t%0d release", idx), {nub_ackn, nub_tm1n, nub_tm0n, nub_adn[28:0]},
          32'hFFFF_FFFF);
    check($sformatf("t%0d release ad", idx), nub_adn, 32'hFFFF_FFFF);
    $display("txn %0d: tmad=%04b addr=%08h wstrb=%04b ack_clk=%0d data=%08h",
             idx, t.tmad, t.addr, t.exp_wstrb, cyc, ~nub_adn);
  endtask

  task automatic do_miss(input int idx, input logic [3:0] id, input logic [31:0] addr);
    bit saw_valid, saw_ack, saw_bus;
    saw_valid = 0; saw_ack = 0; saw_bus = 0;
    start_cycle(id, TMAD_RD_WORD, addr);
    @(posedge nub_clkn); #1;
    nub_startn = 1'b1;
    drv_tm_en  = 1'b0;
    drv_ad_en  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mem_valid !== 1'b0) saw_valid = 1;
      if (nub_ackn !== 1'b1) saw_ack = 1;
      if (nub_adn !== 32'hFFFF_FFFF || nub_tm1n !== 1'b1 || nub_tm0n !== 1'b1) saw_bus = 1;
      @(posedge nub_clkn);
    end
    check($sformatf("miss%0d mem_valid", idx), {31'd0, saw_valid}, 32'd0);
    check($sformatf("miss%0d ack", idx), {31'd0, saw_ack}, 32'd0);
    check($sformatf("miss%0d bus", idx), {31'd0, saw_bus}, 32'd0);
    $display("miss %0d: id=%0h addr=%08h valid=%0d ack=%0d bus=%0d",
             idx, id, addr, saw_valid, saw_ack, saw_bus);
  endtask

  txn_t tbl [17];

  initial begin
    bit saw_ack;
    n_cmp = 0;
    n_fail = 0;
    nub_resetn = 1'b0;
    nub_idn    = 4'hF;
    nub_startn = 1'b1;
    drv_ad_en  = 1'b0;
    drv_ad     = '0;
    drv_tm_en  = 1'b0;
    drv_tm     = 2'b00;

    tbl[0]  = mk(4'h0, TMAD_WR_WORD,   32'hF000_0000, 32'hF000_0000, 4'b1111, 1, 0, 32'h0);
    tbl[1]  = mk(4'h0, TMAD_RD_WORD,   32'hF000_0000, 32'hF000_0000, 4'b0000, 1, 0, 32'h8765_4321);
    tbl[2]  = mk(4'h0, TMAD_WR_HALF_0, 32'hF000_0006, 32'hF000_0004, 4'b0011, 1, 0, 32'h0);
    tbl[3]  = mk(4'h0, TMAD_RD_WORD,   32'hF000_0004, 32'hF000_0004, 4'b0000, 1, 0, 32'h0000_4321);
    tbl[4]  = mk(4'h0, TMAD_WR_HALF_1, 32'hF000_000B, 32'hF000_0008, 4'b1100, 1, 0, 32'h0);
    tbl[5]  = mk(4'h0, TMAD_RD_WORD,   32'hF000_0008, 32'hF000_0008, 4'b0000, 1, 0, 32'h8765_0000);
    tbl[6]  = mk(4'h0, TMAD_WR_BYTE_0, 32'hF000_000C, 32'hF000_000C, 4'b0001, 1, 0, 32'h0);
    tbl[7]  = mk(4'h0, TMAD_RD_WORD,   32'hF000_000C, 32'hF000_000C, 4'b0000, 1, 0, 32'h0000_0021);
    tbl[8]  = mk(4'h0, TMAD_WR_BYTE_1, 32'hF000_0011, 32'hF000_0010, 4'b0010, 1, 0, 32'h0);
    tbl[9]  = mk(4'h0, TMAD_RD_WORD,   32'hF000_0010, 32'hF000_0010, 4'b0000, 1, 0, 32'h0000_4300);
    tbl[10] = mk(4'h0, TMAD_WR_BYTE_2, 32'hF000_0016, 32'hF000_0014, 4'b0100, 1, 0, 32'h0);
    tbl[11] = mk(4'h0, TMAD_RD_WORD,   32'hF000_0014, 32'hF000_0014, 4'b0000, 1, 0, 32'h0065_0000);
    tbl[12] = mk(4'h0, TMAD_WR_BYTE_3, 32'hF000_001B, 32'hF000_0018, 4'b1000, 1, 0, 32'h0);
    tbl[13] = mk(4'h0, TMAD_RD_WORD,   32'hF000_0018, 32'hF000_0018, 4'b0000, 1, 0, 32'h8700_0000);
    tbl[14] = mk(4'h0, TMAD_RD_BLOCK,  32'hF000_0001, 32'hF000_0000, 4'b0000, 1, 0, 32'h8765_4321);
    tbl[15] = mk(4'h0, TMAD_RD_BYTE_3, 32'hF000_000B, 32'hF000_0008, 4'b0000, 1, 0, 32'h8765_0000);
    tbl[16] = mk(4'h3, TMAD_RD_WORD,   32'h3000_0000, 32'h3000_0000, 4'b0000, 0, 1, 32'h8765_4321);

    repeat (3) @(posedge nub_clkn);
    #2;
    check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
    check("reset wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("reset myslot/myexp", {30'd0, mem_myslot, mem_myexp}, 32'd0);
    check("reset ack/tm", {29'd0, nub_ackn, nub_tm1n, nub_tm0n}, 32'd7);
    check("reset ad", nub_adn, 32'hFFFF_FFFF);
    @(posedge nub_clkn); #1;
    nub_resetn = 1'b1;

    for (int i = 0; i < 17; i++) do_txn(i, tbl[i]);

    do_miss(0, 4'h0, 32'hF100_0000);
    do_miss(1, 4'hF, 32'hF000_0000);
    do_miss(2, 4'h0, 32'h0000_0000);

    // reset while waiting on local memory
    start_cycle(4'h0, TMAD_RD_WORD, 32'hF000_0000);
    @(posedge nub_clkn); #1;
    nub_startn = 1'b1;
    drv_tm_en  = 1'b0;
    drv_ad_en  = 1'b0;
    #1;
    check("rst-mid valid before", {31'd0, mem_valid}, 32'd1);
    @(posedge nub_clkn);
    @(posedge nub_clkn); #3;
    nub_resetn = 1'b0;
    #1;
    check("rst-mid valid drop", {31'd0, mem_valid}, 32'd0);
    @(posedge nub_clkn);
    @(posedge nub_clkn); #1;
    nub_resetn = 1'b1;
    saw_ack = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge nub_clkn); #2;
      if (nub_ackn !== 1'b1 || mem_valid !== 1'b0) saw_ack = 1;
    end
    check("rst-mid no ack", {31'd0, saw_ack}, 32'd0);
    $display("reset-abort: ack_or_valid_seen=%0d", saw_ack);
    do_txn(17, tbl[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nubus_slave.md
# nubus_slave

NuBus slave-side bus interface for a NuBus card. It decodes single-beat NuBus transactions addressed to this card's slot space, or to its expansion space. Each accepted transaction becomes a valid/ready request on a simple 32-bit local memory port. The block then returns acknowledge, status and read data on the NuBus. It sits between the NuBus connector pins and the card's local memory or register file.

## Interface
- No parameters.
- Ports:
- nub_clkn  in  1  NuBus clock. Rising edge: block drives outputs. Falling edge: block samples inputs.
- nub_resetn  in  1  reset; asynchronous, active-low.
- nub_idn  in  4  slot ID, active-low; card ID = ~nub_idn.
- nub_adn  inout  32  address/data, active-low, open-collector: drive 0 or Z only.
- nub_tm0n, nub_tm1n  inout  1 each  transfer mode / status, active-low.
- nub_startn  in  1  start, active-low.
- nub_ackn  inout  1  acknowledge, active-low; driven 0 or Z.
- nub_rqstn, nub_arbn[3:0], nub_nmrqn, nub_pfwn, nub_spn, nub_spvn  inout  never driven (always Z).
- mem_valid  out  1  local request.
- mem_ready  in  1  local completion.
- mem_wstrb  out  4  byte-lane write enables; 0000 means read.
- mem_addr  out  32  {address[31:2], 2'b00}.
- mem_wdata  out  32  write data, = ~nub_adn during a write.
- mem_rdata  in  32  read data.
- mem_myslot  out  1  current request hit slot space.
- mem_myexp  out  1  current request hit expansion space.

## Operation
- Decoding of signals: all NuBus signals are inverted internally, so 1 = asserted.
- TM/AD encoding at start is {tm1,tm0,ad1,ad0}:
  - tm1 = 1: write; tm1 = 0: read.
  - tm0 = 0: byte access; lane = ad[1:0]; strobe = 1<<ad.
  - tm0 = 1, ad = 00: word; strobe 1111.
  - tm0 = 1, ad = 01: block, handled as a single word; strobe 1111.
  - tm0 = 1, ad = 10: half 0; strobe 0011.
  - tm0 = 1, ad = 11: half 1; strobe 1100.
- Decode:
  - myslot = addr[31:24] == {4'hF, id}.
  - myexp = addr[31:28] == id, with id ∉ {0, F}.
  - Transaction accepted if myslot | myexp; otherwise ignored, with no ack and no mem_valid.
- States:
  - IDLE: start sampled and decode hit → MEM.
  - MEM: mem_valid = 1; wait for mem_ready sampled high → ACK.
  - ACK: drive ackn = 0 and status {tm1,tm0} = 00 (complete), for one cycle → IDLE.
- Status codes, asserted sense: 00 complete, 01 error, 10 timeout, 11 try-again. Only 00 is generated.
- Read data: on ACK, nub_adn = ~mem_rdata, full 32 bits unmasked.
- Write data: master holds data on nub_adn from the cycle after start until ack.
- nub_adn, nub_tm*n and nub_ackn are Z whenever not in ACK.
- A start seen while in MEM or ACK is ignored.

## Timing
- Cycle Rn/Fn = rising/falling edge of nub_clkn in clock n. Local memory clocks on the falling edge of nub_clkn.
- R0: master asserts start, address, TM. F0: block samples them.
- R1: mem_valid, mem_addr, mem_wstrb, mem_myslot/myexp valid; held until ACK.
- Fk (k ≥ 1): first falling edge with mem_ready = 1.
- R(k+1): mem_valid = 0; ackn, status and read data driven. F(k+1): master samples ack.
- R(k+2): all NuBus outputs released to Z.
- Minimum transaction (mem_ready already 1 at F1) is 3 clocks from start to release.
- Reset (async): state IDLE, mem_valid = 0, mem_wstrb = 0, mem_myslot = mem_myexp = 0, all NuBus outputs Z.
  - Reset mid-transaction aborts the transaction with no ack.

## Structure
- Shared package nubus_pkg holds:
  - TMAD_* codes: {RD,WR}_{WORD, BLOCK, HALF_0, HALF_1, BYTE_0..3}.
  - Status codes: TM_NOP/complete = 00.
  - A strobe-from-TMAD function.
- Single module; no sub-modules. Estimated 150–250 lines.

## Test plan
- ID 0, local memory zero-initialized, 5-clock ready delay.
- Word write 87654321 @F0000000, then word read → read returns 87654321, status 00, ack at the clock after mem_ready.
- Half 0 write 87654321 @F0000004 → wstrb 0011; readback 00004321.
- Half 1 write @F0000008 → wstrb 1100; readback 87650000.
- Byte 0–3 writes @F000000C–F0000018 → wstrb 0001/0010/0100/1000; readbacks 00000021, 00004300, 00650000, 87000000.
- Start @F1000000 with ID 0 → mem_valid stays 0, no ack for 10 clocks, bus stays Z.
- Assert nub_resetn = 0 during MEM → mem_valid drops immediately, no ack. Next transaction completes normally.
